pixel_write_queue: RTL and testbench

- Sits directly downstream of the painter/paint_chess pair, between its pixel stream (paint_x_co, paint_y_co, color, print_enable) and the framebuffer write port of the VGA adapter.
- Converts each multi-cycle print_enable pulse into exactly one buffered write.
- Linearises (x, y) into a framebuffer address and drains the writes one per cycle under fb_ready back-pressure.
- Also provides a full-screen clear sequence, so the painter never writes over stale frames.

---
 rtl/pixel_write_queue.sv | 155 +++++++++++++++
 tb/tb_pixel_write_queue.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_write_queue.sv
// Buffers painter pixel strobes into a small FIFO and drains them to the framebuffer
// write port, with a full-screen clear sequence that runs ahead of any pending pixels.
module pixel_write_queue #(
    parameter int unsigned SCR_WIDTH  = 160,
    parameter int unsigned SCR_HEIGHT = 120,
    parameter int unsigned XW         = 8,
    parameter int unsigned YW         = 7,
    parameter int unsigned CW         = 3,
    parameter int unsigned AW         = 15,
    parameter int unsigned DEPTH      = 8
) (
    input  logic          Clck,
    input  logic          Reset,
    input  logic [XW-1:0] paint_x_co,
    input  logic [YW-1:0] paint_y_co,
    input  logic [CW-1:0] color,
    input  logic          print_enable,
    input  logic          clear_req,
    input  logic [CW-1:0] clear_color,
    input  logic          fb_ready,
    output logic          fb_we,
    output logic [AW-1:0] fb_addr,
    output logic [CW-1:0] fb_data,
    output logic          busy,
    output logic          overflow,
    output logic          dropped_oob
);

    localparam int unsigned PW        = $clog2(DEPTH);
    localparam int unsigned EW        = XW + YW + CW;
    localparam int unsigned NPIX      = SCR_WIDTH * SCR_HEIGHT;
    localparam logic [AW-1:0] LAST_ADDR = AW'(NPIX - 1);
    localparam logic [PW:0]   FULL_CNT  = (PW+1)'(DEPTH);

    typedef enum logic {
        DRAIN = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t state, state_next;

    logic          pe_q;
    logic [EW-1:0] mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [PW:0]   count, count_next;
    logic [AW-1:0] clr_addr;
    logic [CW-1:0] clr_color;

    logic          cap_ev, in_range, push_try, push, pop, ovf_ev, clr_accept;
    logic          fifo_empty, fifo_full;
    logic [XW-1:0] head_x;
    logic [YW-1:0] head_y;
    logic [CW-1:0] head_c;

    logic          we_next;
    logic [AW-1:0] addr_next;
    logic [CW-1:0] data_next;

    // Rising edge of the strobe is the only capture point, whatever the pulse length.
    assign cap_ev     = print_enable && !pe_q;
    assign in_range   = (32'(paint_x_co) < SCR_WIDTH) && (32'(paint_y_co) < SCR_HEIGHT);
    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == FULL_CNT);
    assign clr_accept = (state == DRAIN) && clear_req;
    // A clear request takes the drain slot, so nothing pops on the acceptance edge.
    assign pop        = (state == DRAIN) && !clear_req && !fifo_empty && fb_ready;
    assign push_try   = cap_ev && in_range;
    assign push       = push_try && (!fifo_full || pop);
    assign ovf_ev     = push_try && fifo_full && !pop;
    assign count_next = count + (PW+1)'(push) - (PW+1)'(pop);

    assign head_x = mem[rd_ptr][EW-1 -: XW];
    assign head_y = mem[rd_ptr][CW +: YW];
    assign head_c = mem[rd_ptr][CW-1:0];

    // State register
    always_ff @(posedge Clck) begin
        if (Reset) state <= DRAIN;
        else       state <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            DRAIN: if (clear_req) state_next = CLEAR;
            CLEAR: if (fb_ready && (clr_addr == LAST_ADDR)) state_next = DRAIN;
            default: state_next = DRAIN;
        endcase
    end

    // Next values of the registered write port
    always_comb begin
        we_next   = 1'b0;
        addr_next = fb_addr;
        data_next = fb_data;
        case (state)
            DRAIN: begin
                if (pop) begin
                    we_next   = 1'b1;
                    addr_next = AW'(head_y) * AW'(SCR_WIDTH) + AW'(head_x);
                    data_next = head_c;
                end
            end
            CLEAR: begin
                if (fb_ready) begin
                    we_next   = 1'b1;
                    addr_next = clr_addr;
                    data_next = clr_color;
                end
            end
            default: we_next = 1'b0;
        endcase
    end

    // FIFO storage needs no reset; pointers and count define its contents.
    always_ff @(posedge Clck) begin
        if (push) mem[wr_ptr] <= {paint_x_co, paint_y_co, color};
    end

    always_ff @(posedge Clck) begin
        if (Reset) begin
            pe_q        <= 1'b0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            clr_addr    <= '0;
            clr_color   <= '0;
            fb_we       <= 1'b0;
            fb_addr     <= '0;
            fb_data     <= '0;
            busy        <= 1'b0;
            overflow    <= 1'b0;
            dropped_oob <= 1'b0;
        end else begin
            pe_q    <= print_enable;
            fb_we   <= we_next;
            fb_addr <= addr_next;
            fb_data <= data_next;
            count   <= count_next;
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            if (clr_accept) begin
                clr_addr  <= '0;
                clr_color <= clear_color;
            end else if ((state == CLEAR) && fb_ready) begin
                clr_addr <= clr_addr + AW'(1);
            end
            busy <= (state_next == CLEAR) || (count_next != '0);
            if (ovf_ev)                overflow    <= 1'b1;
            if (cap_ev && !in_range)   dropped_oob <= 1'b1;
        end
    end

endmodule

// File: tb/tb_pixel_write_queue.sv
// Scoreboard bench for pixel_write_queue: stimulus pushes expected framebuffer writes,
// a negedge monitor pops and compares every fb_we pulse.
module tb_pixel_write_queue;

    localparam int W     = 160;
    localparam int H     = 120;
    localparam int DEPTH = 8;

    logic        Clck = 1'b0;
    logic        Reset = 1'b1;
    logic [7:0]  paint_x_co = '0;
    logic [6:0]  paint_y_co = '0;
    logic [2:0]  color = '0;
    logic        print_enable = 1'b0;
    logic        clear_req = 1'b0;
    logic [2:0]  clear_color = '0;
    logic        fb_ready = 1'b0;
    logic        fb_we;
    logic [14:0] fb_addr;
    logic [2:0]  fb_data;
    logic        busy, overflow, dropped_oob;

    pixel_write_queue dut (
        .Clck(Clck), .Reset(Reset),
        .paint_x_co(paint_x_co), .paint_y_co(paint_y_co), .color(color),
        .print_enable(print_enable), .clear_req(clear_req), .clear_color(clear_color),
        .fb_ready(fb_ready), .fb_we(fb_we), .fb_addr(fb_addr), .fb_data(fb_data),
        .busy(busy), .overflow(overflow), .dropped_oob(dropped_oob)
    );

    always #5 Clck = ~Clck;

    logic [17:0] sb[$];
    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int wr_cyc = 0;
    int wr_count = 0;
    logic wr_busy = 1'b0;
    int cap_cyc = 0;
    bit rand_mode = 1'b0;
    bit ready_fixed = 1'b0;

    always @(posedge Clck) cyc <= cyc + 1;

    // Single driver for fb_ready: fixed level or random back-pressure.
    always @(posedge Clck) begin
        #1;
        if (rand_mode) fb_ready = ($urandom_range(0, 3) != 0);
        else           fb_ready = ready_fixed;
    end

    // Monitor: every write must match the head of the expected queue.
    always @(negedge Clck) begin
        logic [17:0] exp_w;
        if (fb_we === 1'b1) begin
            wr_count = wr_count + 1;
            wr_cyc   = cyc;
            wr_busy  = busy;
            tests    = tests + 1;
            if (sb.size() == 0) begin
                fails = fails + 1;
                $display("FAIL unexpected_write: got addr=%0d data=%0d, required no write", fb_addr, fb_data);
            end else begin
                exp_w = sb.pop_front();
                if ({fb_addr, fb_data} !== exp_w) begin
                    fails = fails + 1;
                    $display("FAIL write: got addr=%0d data=%0d, required addr=%0d data=%0d",
                             fb_addr, fb_data, exp_w[17:3], exp_w[2:0]);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        tests = tests + 1;
        if (act !== exp_v) begin
            fails = fails + 1;
            $display("FAIL %s: got %0d, required %0d", name, act, exp_v);
        end
    endtask

    // One painter pulse; the model predicts acceptance from the screen bounds and FIFO level.
    task automatic pixel(input int x, input int y, input int c, input int len, input bit no_full = 1'b0);
        @(posedge Clck); #1;
        paint_x_co   = 8'(x);
        paint_y_co   = 7'(y);
        color        = 3'(c);
        print_enable = 1'b1;
        cap_cyc      = cyc;
        if (x < W && y < H && (no_full || sb.size() < DEPTH))
            sb.push_back({15'(y * W + x), 3'(c)});
        repeat (len) @(posedge Clck);
        #1 print_enable = 1'b0;
        @(posedge Clck); #1;
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(posedge Clck); n++;
        end
        repeat (4) @(posedge Clck);
        #1;
        check({name, "_pending"}, 32'(sb.size()), 32'd0);
    endtask

    task automatic wait_writes(input int target, input int budget);
        int n = 0;
        while (wr_count < target && n < budget) begin
            @(posedge Clck); n++;
        end
        #1;
        if (wr_count < target) check("write_progress_timeout", 32'(wr_count), 32'(target));
    endtask

    task automatic start_clear(input int col);
        @(posedge Clck); #1;
        clear_req   = 1'b1;
        clear_color = 3'(col);
        @(posedge Clck); #1;
        clear_req = 1'b0;
    endtask

    initial begin
        int base;
        logic [17:0] held[$];

        repeat (3) @(posedge Clck);
        #1 Reset = 1'b0;
        check("rst_fb_we", 32'(fb_we), 32'd0);
        check("rst_fb_addr", 32'(fb_addr), 32'd0);
        check("rst_fb_data", 32'(fb_data), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_dropped_oob", 32'(dropped_oob), 32'd0);

        // Single pixel and its latency
        ready_fixed = 1'b1;
        repeat (3) @(posedge Clck);
        base = wr_count;
        pixel(5, 3, 6, 3);
        wait_drain("single", 50);
        check("single_count", 32'(wr_count - base), 32'd1);
        check("single_latency", 32'(wr_cyc - cap_cyc), 32'd2);
        check("single_busy_falls", 32'(wr_busy), 32'd0);

        // Long pulse yields one write; a new rising edge yields another
        base = wr_count;
        pixel(10, 10, 2, 20);
        pixel(11, 10, 5, 3);
        wait_drain("long", 50);
        check("long_count", 32'(wr_count - base), 32'd2);

        // Back-pressure: 8 buffered, 9th dropped
        ready_fixed = 1'b0;
        repeat (3) @(posedge Clck);
        base = wr_count;
        for (int i = 0; i < 9; i++) pixel(20 + i, 40 + i, i % 8, 3);
        check("ovf_no_writes", 32'(wr_count - base), 32'd0);
        check("ovf_busy", 32'(busy), 32'd1);
        check("ovf_set", 32'(overflow), 32'd1);
        ready_fixed = 1'b1;
        wait_drain("ovf", 100);
        check("ovf_drain_count", 32'(wr_count - base), 32'd8);
        check("ovf_sticky", 32'(overflow), 32'd1);

        // Out of range
        check("oob_clear", 32'(dropped_oob), 32'd0);
        base = wr_count;
        pixel(160, 0, 3, 3);
        pixel(0, 120, 3, 3);
        pixel(159, 119, 7, 3);
        wait_drain("oob", 50);
        check("oob_set", 32'(dropped_oob), 32'd1);
        check("oob_count", 32'(wr_count - base), 32'd1);

        // Random pixels under random back-pressure
        rand_mode = 1'b1;
        for (int i = 0; i < 60; i++) begin
            int n = 0;
            while (sb.size() >= DEPTH - 1 && n < 200) begin
                @(posedge Clck); n++;
            end
            pixel($urandom_range(0, 170), $urandom_range(0, 125), $urandom_range(0, 7),
                  $urandom_range(3, 6));
        end
        wait_drain("random", 500);
        rand_mode = 1'b0;

        // Clear with a pending pixel retained behind it
        ready_fixed = 1'b0;
        repeat (3) @(posedge Clck);
        pixel(0, 0, 4, 3);
        repeat (2) @(posedge Clck);
        held = sb;
        sb.delete();
        for (int a = 0; a < W * H; a++) sb.push_back({15'(a), 3'(1)});
        foreach (held[i]) sb.push_back(held[i]);
        base = wr_count;
        start_clear(1);
        check("clear_busy", 32'(busy), 32'd1);
        rand_mode = 1'b1;
        wait_writes(base + 1000, 5000);
        start_clear(5);
        wait_drain("clear", 60000);
        rand_mode = 1'b0;
        check("clear_count", 32'(wr_count - base), 32'(W * H + 1));
        check("clear_idle", 32'(busy), 32'd0);

        // Reset mid-clear abandons clear and FIFO contents
        ready_fixed = 1'b1;
        repeat (2) @(posedge Clck);
        for (int a = 0; a < W * H; a++) sb.push_back({15'(a), 3'(2)});
        base = wr_count;
        start_clear(2);
        wait_writes(base + 100, 1000);
        pixel(7, 7, 5, 3, 1'b1);
        wait_writes(base + 5000, 10000);
        @(posedge Clck); #1 Reset = 1'b1;
        @(posedge Clck); #1 Reset = 1'b0;
        sb.delete();
        check("rst_mid_fb_we", 32'(fb_we), 32'd0);
        check("rst_mid_busy", 32'(busy), 32'd0);
        check("rst_mid_overflow", 32'(overflow), 32'd0);
        check("rst_mid_oob", 32'(dropped_oob), 32'd0);

        // Restart clears from address 0; no leftover pixel may follow
        for (int a = 0; a < W * H; a++) sb.push_back({15'(a), 3'(3)});
        base = wr_count;
        start_clear(3);
        wait_drain("restart", 25000);
        repeat (10) @(posedge Clck);
        #1;
        check("restart_count", 32'(wr_count - base), 32'(W * H));
        check("restart_idle", 32'(busy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
